mush_jump_control: RTL
======================

Name: mush_jump_control

Overview:
- Frame-sequencing FSM that drives the Mush-Jump pixel datapath.
- Per frame: sweeps the 160x120 scrolling background, then the 15x16 character sprite. Then it waits for the frame tick, advances the scroll by one column and steps the jump trajectory.
- Sits directly upstream of the datapath: produces its enable/select strobes and consumes its doneP/doneC/ground flags. Also generates the VGA adapter write strobe.

Parameters:
- JUMP_HEIGHT, 30: rise steps per jump; the fall uses the same number of steps.
- SCROLL_DIV, 1: frames per one-column background shift (1..15).
- PLOT_LAT, 2: cycles from counter advance to valid colour (RAM read + colour select register).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  level; leave IDLE and begin the game
- jump_key  in  1  raw asynchronous key, active-high
- frame_tick  in  1  one-cycle pulse per display frame
- doneP  in  1  one-cycle pulse: background sweep finished
- doneC  in  1  one-cycle pulse: sprite sweep finished
- ground  in  1  character on ground when 1
- drawB  out  1  background path select
- drawC  out  1  character path select
- enableX  out  1  background x-counter enable
- enableCountXC  out  1  sprite x-counter enable
- enableShift  out  1  scroll offset increment
- countUp  out  1  raise character one row
- countDown  out  1  lower character one row
- plot  out  1  VGA write enable, aligned with colour
- frame_cnt  out  16  completed frames, wraps at 0xFFFF

Behaviour:
- Reset (resetn low, asynchronous): state = IDLE; all outputs 0; frame_cnt 0; jump phase GROUNDED; counters cleared; plot pipeline flushed.
- Reset mid-sweep: plot drops to 0 in the same asynchronous assertion.
- jump_key: two-flop synchroniser, then rising-edge detect. A detected edge sets jump_req.
  - jump_req is latched only when phase = GROUNDED and ground = 1; otherwise the edge is dropped.
  - jump_req clears when consumed in MOVE.
- IDLE: all outputs 0. Go to BG when start = 1.
- BG: drawB = 1, enableX = 1, drawC = 0. Hold until doneP = 1, then go to CHAR.
- CHAR: drawC = 1, enableCountXC = 1, drawB = 0. Hold until doneC = 1, then go to WAIT; frame_cnt increments on that transition.
- WAIT: drawB = drawC = 0. On frame_tick, the scroll-divider counter increments.
  - Divider reaches SCROLL_DIV-1: counter clears; go to SHIFT.
  - Otherwise: go to MOVE.
- SHIFT: exactly one cycle with drawB = 1, enableShift = 1, enableX = 0. Then go to MOVE.
- MOVE: exactly one cycle with drawC = 1, enableCountXC = 0.
  - GROUNDED with jump_req: countUp = 1, rise_cnt = 1, phase = RISING.
  - RISING: countUp = 1, rise_cnt increments; at rise_cnt = JUMP_HEIGHT, phase = FALLING and fall_cnt = 0.
  - FALLING: countDown = 1, fall_cnt increments; at fall_cnt = JUMP_HEIGHT, phase = GROUNDED.
  - countUp and countDown are never asserted together.
  - Then go to BG.
- drawB and drawC are never both 1.
- All strobe outputs are registered Moore outputs, valid the cycle after entering a state.
- plot: draw_active (BG or CHAR) delayed through a PLOT_LAT-deep shift register.
  - Neither the trailing PLOT_LAT cycles after doneP nor the sweep start are suppressed.
  - Pipeline clears only on reset.
- frame_tick arriving outside WAIT is ignored; it is not queued.
- start deasserted mid-game has no effect; only reset returns to IDLE.

Optional Feature:
- Macro: MUSHJUMP_PAUSE_EN.
- Defined: adds input pause (level).
  - While pause = 1 in WAIT, frame_tick is ignored, no SHIFT/MOVE occurs, and the jump phase and counters are frozen.
  - A sweep in progress always completes.
  - jump edges during pause are discarded.
- Undefined: no pause port; behaviour as above.

Test Plan:
- Reset then start = 1, model doneP after 19200 BG cycles: drawB/enableX high exactly 19200+1 cycles; plot rises 2 cycles after drawB and falls 2 cycles after it.
- Full frame with SCROLL_DIV = 1: sequence BG -> CHAR -> WAIT -> (frame_tick) SHIFT (enableShift for 1 cycle) -> MOVE -> BG; frame_cnt = 1 after doneC.
- jump_key pulse while ground = 1 with JUMP_HEIGHT = 30: countUp asserted in the next 30 MOVE cycles, then countDown in 30 MOVE cycles, then neither.
- jump_key pressed during RISING, or while ground = 0: ignored; total rise remains 30 steps.
- SCROLL_DIV = 3, 6 frames: enableShift pulses exactly twice; MOVE occurs every frame.
- resetn low mid-BG (asynchronous, between clk edges): drawB, enableX and plot go 0 immediately; after release state is IDLE and frame_cnt = 0.

Source files
------------

// File: rtl/mush_jump_control.sv
// Frame-sequencing FSM for the Mush-Jump pixel datapath: background sweep, sprite sweep, scroll and jump.
// Optional MUSHJUMP_PAUSE_EN adds a level 'pause' input that freezes the game while it sits in WAIT.
module mush_jump_control #(
  parameter int JUMP_HEIGHT = 30,
  parameter int SCROLL_DIV  = 1,
  parameter int PLOT_LAT    = 2
) (
`ifdef MUSHJUMP_PAUSE_EN
  input  logic        pause,
`endif
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        jump_key,
  input  logic        frame_tick,
  input  logic        doneP,
  input  logic        doneC,
  input  logic        ground,
  output logic        drawB,
  output logic        drawC,
  output logic        enableX,
  output logic        enableCountXC,
  output logic        enableShift,
  output logic        countUp,
  output logic        countDown,
  output logic        plot,
  output logic [15:0] frame_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_BG, S_CHAR, S_WAIT, S_SHIFT, S_MOVE} state_t;
  typedef enum logic [1:0] {PH_GROUNDED, PH_RISING, PH_FALLING} phase_t;

  localparam int             CW        = $clog2(JUMP_HEIGHT + 1);
  localparam logic [CW-1:0]  LAST_STEP = CW'(JUMP_HEIGHT - 1);
  localparam logic [3:0]     DIV_LAST  = 4'(SCROLL_DIV - 1);

  state_t              r_state, w_next_state;
  phase_t              r_phase;
  logic [CW-1:0]       r_rise_cnt, r_fall_cnt;
  logic [3:0]          r_div;
  logic                r_jump_req;
  logic                r_key_meta, r_key_sync, r_key_prev;
  logic                r_active;
  logic [PLOT_LAT-1:0] r_plot_pipe;
  logic [15:0]         r_frame_cnt;
  logic                r_draw_b, r_draw_c, r_en_x, r_en_xc, r_en_shift, r_up, r_down;

  logic w_pause, w_key_rise, w_tick_taken, w_move_up;
  logic w_draw_b, w_draw_c, w_en_x, w_en_xc, w_en_shift, w_up, w_down;

`ifdef MUSHJUMP_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = 1'b0;
`endif

  assign w_key_rise = r_key_sync & ~r_key_prev;
  assign w_move_up  = (r_phase == PH_RISING) || ((r_phase == PH_GROUNDED) && r_jump_req);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_key_meta <= 1'b0;
      r_key_sync <= 1'b0;
      r_key_prev <= 1'b0;
      r_state    <= S_IDLE;
    end else begin
      r_key_meta <= jump_key;
      r_key_sync <= r_key_meta;
      r_key_prev <= r_key_sync;
      r_state    <= w_next_state;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_draw_b     = 1'b0;
    w_draw_c     = 1'b0;
    w_en_x       = 1'b0;
    w_en_xc      = 1'b0;
    w_en_shift   = 1'b0;
    w_up         = 1'b0;
    w_down       = 1'b0;
    w_tick_taken = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_BG;
      S_BG: begin
        w_draw_b = 1'b1;
        w_en_x   = 1'b1;
        if (doneP) w_next_state = S_CHAR;
      end
      S_CHAR: begin
        w_draw_c = 1'b1;
        w_en_xc  = 1'b1;
        if (doneC) w_next_state = S_WAIT;
      end
      S_WAIT: begin
        if (frame_tick && !w_pause) begin
          w_tick_taken = 1'b1;
          w_next_state = (r_div == DIV_LAST) ? S_SHIFT : S_MOVE;
        end
      end
      S_SHIFT: begin
        w_draw_b     = 1'b1;
        w_en_shift   = 1'b1;
        w_next_state = S_MOVE;
      end
      S_MOVE: begin
        w_draw_c     = 1'b1;
        w_up         = w_move_up;
        w_down       = (r_phase == PH_FALLING);
        w_next_state = S_BG;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Strobes are registered from the state decode, so they lag the state by one cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_draw_b    <= 1'b0;
      r_draw_c    <= 1'b0;
      r_en_x      <= 1'b0;
      r_en_xc     <= 1'b0;
      r_en_shift  <= 1'b0;
      r_up        <= 1'b0;
      r_down      <= 1'b0;
      r_active    <= 1'b0;
      r_plot_pipe <= '0;
    end else begin
      r_draw_b       <= w_draw_b;
      r_draw_c       <= w_draw_c;
      r_en_x         <= w_en_x;
      r_en_xc        <= w_en_xc;
      r_en_shift     <= w_en_shift;
      r_up           <= w_up;
      r_down         <= w_down;
      r_active       <= (r_state == S_BG) || (r_state == S_CHAR);
      r_plot_pipe[0] <= r_active;
      for (int i = 1; i < PLOT_LAT; i++) r_plot_pipe[i] <= r_plot_pipe[i-1];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_frame_cnt <= '0;
      r_div       <= '0;
    end else begin
      if ((r_state == S_CHAR) && doneC) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_tick_taken) r_div <= (r_div == DIV_LAST) ? 4'd0 : r_div + 4'd1;
    end
  end

  // Jump trajectory: a latched request is consumed by the next MOVE; each MOVE steps one row.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_phase    <= PH_GROUNDED;
      r_rise_cnt <= '0;
      r_fall_cnt <= '0;
      r_jump_req <= 1'b0;
    end else begin
      if (w_key_rise && (r_phase == PH_GROUNDED) && ground && !w_pause) r_jump_req <= 1'b1;
      if (r_state == S_MOVE) begin
        case (r_phase)
          PH_GROUNDED: begin
            if (r_jump_req) begin
              r_jump_req <= 1'b0;
              r_rise_cnt <= CW'(1);
              r_fall_cnt <= '0;
              r_phase    <= (JUMP_HEIGHT == 1) ? PH_FALLING : PH_RISING;
            end
          end
          PH_RISING: begin
            r_rise_cnt <= r_rise_cnt + 1'b1;
            if (r_rise_cnt == LAST_STEP) begin
              r_phase    <= PH_FALLING;
              r_fall_cnt <= '0;
            end
          end
          PH_FALLING: begin
            r_fall_cnt <= r_fall_cnt + 1'b1;
            if (r_fall_cnt == LAST_STEP) begin
              r_phase    <= PH_GROUNDED;
              r_rise_cnt <= '0;
              r_fall_cnt <= '0;
            end
          end
          default: r_phase <= PH_GROUNDED;
        endcase
      end
    end
  end

  assign drawB         = r_draw_b;
  assign drawC         = r_draw_c;
  assign enableX       = r_en_x;
  assign enableCountXC = r_en_xc;
  assign enableShift   = r_en_shift;
  assign countUp       = r_up;
  assign countDown     = r_down;
  assign plot          = r_plot_pipe[PLOT_LAT-1];
  assign frame_cnt     = r_frame_cnt;

endmodule
